// File: rtl/nnrv_pkg.sv
// Shared encodings for the nn_riscv load/store alignment stage.
package nnrv_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_ACCESS = 1'b0,
    ST_SECOND = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/nnrv_load_extract.sv
// Right-aligns a loaded dword by byte offset, keeps the accessed width and extends it.
module nnrv_load_extract
  import nnrv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      off,
  input  logic [1:0]      size,
  input  logic            sign,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted_s;

  assign shifted_s = data >> {off, 3'b000};

  // Width select with optional sign extension; a dword ignores sign.
  always_comb begin
    result = '0;
    case (size)
      SZ_B:    result = {{(XLEN-8){sign & shifted_s[7]}}, shifted_s[7:0]};
      SZ_H:    result = {{(XLEN-16){sign & shifted_s[15]}}, shifted_s[15:0]};
      SZ_W:    result = {{(XLEN-32){sign & shifted_s[31]}}, shifted_s[31:0]};
      SZ_D:    result = shifted_s;
      default: result = shifted_s;
    endcase
  end

endmodule

// File: rtl/nnrv_lsu_align.sv
// Load/store alignment: dword-aligned RAM beats with byte masks, two-beat split
// for accesses crossing a dword boundary, registered writeback result.
module nnrv_lsu_align
  import nnrv_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int MASK_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_exec_valid,
  input  logic                  i_exec_ld,
  input  logic                  i_exec_st,
  input  logic [XLEN-1:0]       i_exec_addr,
  input  logic [1:0]            i_exec_size,
  input  logic                  i_exec_sign,
  input  logic [XLEN-1:0]       i_exec_wdata,
  input  logic                  i_exec_rd_en,
  input  logic [4:0]            i_exec_rd,
  input  logic [XLEN-1:0]       i_exec_rd_reg,
  output logic                  o_exec_stall,
  output logic                  o_ram_rd_en,
  output logic                  o_ram_wr_en,
  output logic [XLEN-1:0]       o_ram_addr,
  output logic [MASK_WIDTH-1:0] o_ram_mask,
  output logic [XLEN-1:0]       o_ram_wr_data,
  input  logic [XLEN-1:0]       i_ram_rd_data,
  output logic                  o_wb_valid,
  output logic                  o_wb_rd_en,
  output logic [4:0]            o_wb_rd,
  output logic [XLEN-1:0]       o_wb_rd_reg
);

  lsu_state_e          state_r, state_nxt_s;
  logic [XLEN-1:0]     hold_r;
  logic [2:0]          off_s;
  logic [3:0]          nb_s;
  logic [15:0]         m16_s;
  logic [2*XLEN-1:0]   d128_s;
  logic [2*XLEN-1:0]   pair_s;
  logic [XLEN-1:0]     lo_addr_s;
  logic [XLEN-1:0]     ext_data_s;
  logic [2:0]          ext_off_s;
  logic [XLEN-1:0]     load_s;
  logic                split_s, mem_s, ld_s, st_s, stall_s, do_wb_s;

  assign off_s     = i_exec_addr[2:0];
  assign nb_s      = 4'd1 << i_exec_size;
  assign m16_s     = ((16'd1 << nb_s) - 16'd1) << off_s;
  assign d128_s    = {{XLEN{1'b0}}, i_exec_wdata} << {off_s, 3'b000};
  assign split_s   = |m16_s[15:8];
  assign st_s      = i_exec_st;
  assign ld_s      = i_exec_ld & ~i_exec_st;
  assign mem_s     = i_exec_ld | i_exec_st;
  assign lo_addr_s = {i_exec_addr[XLEN-1:3], 3'b000};
  assign pair_s    = {i_ram_rd_data, hold_r} >> {off_s, 3'b000};

  // The second beat has already been shifted across both halves.
  assign ext_data_s = (state_r == ST_SECOND) ? pair_s[XLEN-1:0] : i_ram_rd_data;
  assign ext_off_s  = (state_r == ST_SECOND) ? 3'd0 : off_s;

  nnrv_load_extract #(.XLEN(XLEN)) u_extract (
    .data   (ext_data_s),
    .off    (ext_off_s),
    .size   (i_exec_size),
    .sign   (i_exec_sign),
    .result (load_s)
  );

  // Beat selection, RAM request and next state.
  always_comb begin
    state_nxt_s   = state_r;
    stall_s       = 1'b0;
    o_ram_rd_en   = 1'b0;
    o_ram_wr_en   = 1'b0;
    o_ram_addr    = '0;
    o_ram_mask    = '0;
    o_ram_wr_data = '0;
    case (state_r)
      ST_ACCESS: begin
        if (i_exec_valid && mem_s) begin
          o_ram_rd_en   = ld_s;
          o_ram_wr_en   = st_s;
          o_ram_addr    = lo_addr_s;
          o_ram_mask    = m16_s[7:0];
          o_ram_wr_data = d128_s[XLEN-1:0];
          if (split_s) begin
            stall_s     = 1'b1;
            state_nxt_s = ST_SECOND;
          end else begin
            state_nxt_s = ST_ACCESS;
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_SECOND: begin
        o_ram_rd_en   = ld_s;
        o_ram_wr_en   = st_s;
        o_ram_addr    = lo_addr_s + 64'd8;
        o_ram_mask    = m16_s[15:8];
        o_ram_wr_data = d128_s[2*XLEN-1:XLEN];
        state_nxt_s   = ST_ACCESS;
      end
      default: state_nxt_s = ST_ACCESS;
    endcase
  end

  assign o_exec_stall = stall_s & i_rst_n;
  assign do_wb_s = (state_r == ST_SECOND) ||
                   (i_exec_valid && !(mem_s && split_s));

  // State, split-load low half and writeback registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_ACCESS;
      hold_r      <= '0;
      o_wb_valid  <= 1'b0;
      o_wb_rd_en  <= 1'b0;
      o_wb_rd     <= 5'd0;
      o_wb_rd_reg <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_ACCESS && i_exec_valid && ld_s && split_s) begin
        hold_r <= i_ram_rd_data;
      end
      if (do_wb_s) begin
        o_wb_valid <= 1'b1;
        o_wb_rd    <= i_exec_rd;
        if (st_s) begin
          o_wb_rd_en <= 1'b0;
        end else if (ld_s) begin
          o_wb_rd_en  <= i_exec_rd_en;
          o_wb_rd_reg <= load_s;
        end else begin
          o_wb_rd_en  <= i_exec_rd_en;
          o_wb_rd_reg <= i_exec_rd_reg;
        end
      end else begin
        o_wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nnrv_lsu_align.sv
// Directed self-checking bench for nnrv_lsu_align.
module tb_nnrv_lsu_align;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_exec_valid, i_exec_ld, i_exec_st, i_exec_sign, i_exec_rd_en;
  logic [63:0] i_exec_addr, i_exec_wdata, i_exec_rd_reg, i_ram_rd_data;
  logic [1:0]  i_exec_size;
  logic [4:0]  i_exec_rd;
  logic        o_exec_stall, o_ram_rd_en, o_ram_wr_en;
  logic [63:0] o_ram_addr, o_ram_wr_data, o_wb_rd_reg;
  logic [7:0]  o_ram_mask;
  logic        o_wb_valid, o_wb_rd_en;
  logic [4:0]  o_wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  nnrv_lsu_align dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_exec_valid(i_exec_valid), .i_exec_ld(i_exec_ld), .i_exec_st(i_exec_st),
    .i_exec_addr(i_exec_addr), .i_exec_size(i_exec_size), .i_exec_sign(i_exec_sign),
    .i_exec_wdata(i_exec_wdata), .i_exec_rd_en(i_exec_rd_en), .i_exec_rd(i_exec_rd),
    .i_exec_rd_reg(i_exec_rd_reg), .o_exec_stall(o_exec_stall),
    .o_ram_rd_en(o_ram_rd_en), .o_ram_wr_en(o_ram_wr_en), .o_ram_addr(o_ram_addr),
    .o_ram_mask(o_ram_mask), .o_ram_wr_data(o_ram_wr_data), .i_ram_rd_data(i_ram_rd_data),
    .o_wb_valid(o_wb_valid), .o_wb_rd_en(o_wb_rd_en), .o_wb_rd(o_wb_rd),
    .o_wb_rd_reg(o_wb_rd_reg)
  );

  task automatic drive(input logic v, input logic ld, input logic st, input logic [63:0] addr,
                       input logic [1:0] size, input logic sign, input logic [63:0] wdata,
                       input logic rd_en, input logic [4:0] rd, input logic [63:0] rd_reg);
    i_exec_valid = v; i_exec_ld = ld; i_exec_st = st; i_exec_addr = addr;
    i_exec_size = size; i_exec_sign = sign; i_exec_wdata = wdata;
    i_exec_rd_en = rd_en; i_exec_rd = rd; i_exec_rd_reg = rd_reg;
  endtask

  task automatic next_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 2'd0, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0);
    i_ram_rd_data = 64'd0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg} !== 71'd0) begin
      errors++; $display("FAIL reset_wb: got %b/%b/%h/%h exp 0", o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg);
    end
    checks++;
    if ({o_exec_stall, o_ram_rd_en, o_ram_wr_en, o_ram_mask, o_ram_addr, o_ram_wr_data} !== 139'd0) begin
      errors++; $display("FAIL reset_ram: got stall=%b rd=%b wr=%b mask=%h addr=%h exp 0",
                         o_exec_stall, o_ram_rd_en, o_ram_wr_en, o_ram_mask, o_ram_addr);
    end
    i_rst_n = 1'b1;
    next_edge();
  endtask

  task automatic test_lw();
    drive(1'b1, 1'b1, 1'b0, 64'h1004, 2'd2, 1'b1, 64'd0, 1'b1, 5'd3, 64'd0);
    i_ram_rd_data = 64'h8765432111223344;
    #1;
    checks++;
    if ({o_ram_rd_en, o_ram_wr_en, o_exec_stall, o_ram_mask, o_ram_addr} !== {3'b100, 8'hF0, 64'h1000}) begin
      errors++; $display("FAIL lw_beat: got rd=%b wr=%b stall=%b mask=%h addr=%h exp 1 0 0 f0 1000",
                         o_ram_rd_en, o_ram_wr_en, o_exec_stall, o_ram_mask, o_ram_addr);
    end
    next_edge();
    checks++;
    if ({o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg} !== {2'b11, 5'd3, 64'hFFFFFFFF87654321}) begin
      errors++; $display("FAIL lw_wb: got v=%b en=%b rd=%0d data=%h exp 1 1 3 ffffffff87654321",
                         o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg);
    end
  endtask

  task automatic test_lb_lbu();
    drive(1'b1, 1'b1, 1'b0, 64'h2007, 2'd0, 1'b0, 64'd0, 1'b1, 5'd7, 64'd0);
    i_ram_rd_data = 64'hAB00000000000000;
    #1;
    checks++;
    if ({o_ram_mask, o_ram_addr, o_exec_stall} !== {8'h80, 64'h2000, 1'b0}) begin
      errors++; $display("FAIL lbu_beat: got mask=%h addr=%h stall=%b exp 80 2000 0", o_ram_mask, o_ram_addr, o_exec_stall);
    end
    next_edge();
    checks++;
    if (o_wb_rd_reg !== 64'h00000000000000AB) begin
      errors++; $display("FAIL lbu_wb: got %h exp 00000000000000ab", o_wb_rd_reg);
    end
    i_exec_sign = 1'b1;
    next_edge();
    checks++;
    if (o_wb_rd_reg !== 64'hFFFFFFFFFFFFFFAB) begin
      errors++; $display("FAIL lb_wb: got %h exp ffffffffffffffab", o_wb_rd_reg);
    end
  endtask

  task automatic test_split_store();
    drive(1'b1, 1'b0, 1'b1, 64'h3005, 2'd3, 1'b0, 64'h0102030405060708, 1'b1, 5'd9, 64'd0);
    #1;
    checks++;
    if ({o_ram_wr_en, o_ram_rd_en, o_exec_stall, o_ram_mask, o_ram_addr} !== {3'b101, 8'hE0, 64'h3000}) begin
      errors++; $display("FAIL sd_beat0: got wr=%b rd=%b stall=%b mask=%h addr=%h exp 1 0 1 e0 3000",
                         o_ram_wr_en, o_ram_rd_en, o_exec_stall, o_ram_mask, o_ram_addr);
    end
    checks++;
    if (o_ram_wr_data[63:40] !== 24'h060708) begin
      errors++; $display("FAIL sd_data0: got %h exp 060708 in top bytes", o_ram_wr_data);
    end
    next_edge();
    checks++;
    if (o_wb_valid !== 1'b0) begin
      errors++; $display("FAIL sd_wb_mid: got valid=%b exp 0", o_wb_valid);
    end
    checks++;
    if ({o_ram_wr_en, o_exec_stall, o_ram_mask, o_ram_addr, o_ram_wr_data} !==
        {2'b10, 8'h1F, 64'h3008, 64'h0000000102030405}) begin
      errors++; $display("FAIL sd_beat1: got wr=%b stall=%b mask=%h addr=%h data=%h exp 1 0 1f 3008 0000000102030405",
                         o_ram_wr_en, o_exec_stall, o_ram_mask, o_ram_addr, o_ram_wr_data);
    end
    next_edge();
    checks++;
    if ({o_wb_valid, o_wb_rd_en} !== 2'b10) begin
      errors++; $display("FAIL sd_wb: got valid=%b rd_en=%b exp 1 0", o_wb_valid, o_wb_rd_en);
    end
  endtask

  task automatic test_split_load();
    drive(1'b1, 1'b1, 1'b0, 64'h4006, 2'd3, 1'b0, 64'd0, 1'b1, 5'd12, 64'd0);
    i_ram_rd_data = 64'h2211000000000000;
    #1;
    checks++;
    if ({o_ram_rd_en, o_exec_stall, o_ram_mask, o_ram_addr} !== {2'b11, 8'hC0, 64'h4000}) begin
      errors++; $display("FAIL ld_beat0: got rd=%b stall=%b mask=%h addr=%h exp 1 1 c0 4000",
                         o_ram_rd_en, o_exec_stall, o_ram_mask, o_ram_addr);
    end
    next_edge();
    i_ram_rd_data = 64'h0000887766554433;
    #1;
    checks++;
    if ({o_ram_rd_en, o_exec_stall, o_ram_mask, o_ram_addr} !== {2'b10, 8'h3F, 64'h4008}) begin
      errors++; $display("FAIL ld_beat1: got rd=%b stall=%b mask=%h addr=%h exp 1 0 3f 4008",
                         o_ram_rd_en, o_exec_stall, o_ram_mask, o_ram_addr);
    end
    next_edge();
    checks++;
    if ({o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg} !== {2'b11, 5'd12, 64'h8877665544332211}) begin
      errors++; $display("FAIL ld_split_wb: got v=%b en=%b rd=%0d data=%h exp 1 1 12 8877665544332211",
                         o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg);
    end
  endtask

  task automatic test_nonmem_and_idle();
    drive(1'b1, 1'b0, 1'b0, 64'h5003, 2'd3, 1'b0, 64'd0, 1'b1, 5'd5, 64'h42);
    #1;
    checks++;
    if ({o_ram_rd_en, o_ram_wr_en, o_exec_stall} !== 3'b000) begin
      errors++; $display("FAIL alu_strobes: got rd=%b wr=%b stall=%b exp 0 0 0", o_ram_rd_en, o_ram_wr_en, o_exec_stall);
    end
    next_edge();
    checks++;
    if ({o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg} !== {2'b11, 5'd5, 64'h42}) begin
      errors++; $display("FAIL alu_wb: got v=%b en=%b rd=%0d data=%h exp 1 1 5 42",
                         o_wb_valid, o_wb_rd_en, o_wb_rd, o_wb_rd_reg);
    end
    i_exec_valid = 1'b0;
    i_exec_rd_reg = 64'h99;
    next_edge();
    checks++;
    if ({o_wb_valid, o_wb_rd_reg, o_ram_rd_en, o_ram_wr_en, o_ram_mask} !== {1'b0, 64'h42, 10'd0}) begin
      errors++; $display("FAIL idle: got v=%b data=%h rd=%b wr=%b mask=%h exp 0 42 0 0 00",
                         o_wb_valid, o_wb_rd_reg, o_ram_rd_en, o_ram_wr_en, o_ram_mask);
    end
  endtask

  task automatic test_ld_st_both();
    drive(1'b1, 1'b1, 1'b1, 64'h6000, 2'd3, 1'b0, 64'hCAFEF00D12345678, 1'b1, 5'd8, 64'd0);
    #1;
    checks++;
    if ({o_ram_rd_en, o_ram_wr_en, o_ram_mask, o_ram_wr_data} !== {2'b01, 8'hFF, 64'hCAFEF00D12345678}) begin
      errors++; $display("FAIL ldst_beat: got rd=%b wr=%b mask=%h data=%h exp 0 1 ff cafef00d12345678",
                         o_ram_rd_en, o_ram_wr_en, o_ram_mask, o_ram_wr_data);
    end
    next_edge();
    checks++;
    if ({o_wb_valid, o_wb_rd_en} !== 2'b10) begin
      errors++; $display("FAIL ldst_wb: got valid=%b rd_en=%b exp 1 0", o_wb_valid, o_wb_rd_en);
    end
  endtask

  task automatic test_reset_in_second();
    drive(1'b1, 1'b1, 1'b0, 64'h4006, 2'd3, 1'b0, 64'd0, 1'b1, 5'd12, 64'd0);
    i_ram_rd_data = 64'h2211000000000000;
    next_edge();
    i_rst_n = 1'b0;
    i_exec_valid = 1'b0;
    #1;
    checks++;
    if ({o_wb_valid, o_exec_stall} !== 2'b00) begin
      errors++; $display("FAIL rst2_out: got valid=%b stall=%b exp 0 0", o_wb_valid, o_exec_stall);
    end
    next_edge();
    i_rst_n = 1'b1;
    #1;
    checks++;
    if ({o_ram_rd_en, o_ram_addr, o_ram_mask} !== 73'd0) begin
      errors++; $display("FAIL rst2_state: got rd=%b addr=%h mask=%h exp 0 0 00", o_ram_rd_en, o_ram_addr, o_ram_mask);
    end
    next_edge();
    drive(1'b1, 1'b1, 1'b0, 64'h1004, 2'd2, 1'b0, 64'd0, 1'b1, 5'd4, 64'd0);
    i_ram_rd_data = 64'h8765432111223344;
    #1;
    checks++;
    if ({o_exec_stall, o_ram_mask, o_ram_addr} !== {1'b0, 8'hF0, 64'h1000}) begin
      errors++; $display("FAIL rst2_next_beat: got stall=%b mask=%h addr=%h exp 0 f0 1000", o_exec_stall, o_ram_mask, o_ram_addr);
    end
    next_edge();
    checks++;
    if ({o_wb_valid, o_wb_rd, o_wb_rd_reg} !== {1'b1, 5'd4, 64'h0000000087654321}) begin
      errors++; $display("FAIL rst2_next_wb: got v=%b rd=%0d data=%h exp 1 4 0000000087654321", o_wb_valid, o_wb_rd, o_wb_rd_reg);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_split_store();
    test_split_load();
    test_nonmem_and_idle();
    test_ld_st_both();
    test_reset_in_second();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nnrv_lsu_align.md
Name: nnrv_lsu_align

Overview:
Load/store alignment stage between the exec stage and the memory-access stage of the nn_riscv pipeline. It turns exec's byte address, access size and store data into dword-aligned RAM requests with byte masks, and right-aligns and sign- or zero-extends load data. An access that crosses a 64-bit boundary is split into two RAM beats by a small FSM, which stalls exec for one cycle. The result is registered toward the memory/writeback path.

Parameters:
XLEN, 64, data/address width; only 64 is supported.
MASK_WIDTH, 8, byte-mask width, equal to XLEN/8.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active low
i_exec_valid  in  1  exec presents an instruction this cycle
i_exec_ld  in  1  instruction is a load
i_exec_st  in  1  instruction is a store
i_exec_addr  in  XLEN  byte address
i_exec_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword
i_exec_sign  in  1  sign-extend the load result
i_exec_wdata  in  XLEN  store data, right-aligned
i_exec_rd_en  in  1  instruction writes rd
i_exec_rd  in  5  destination register
i_exec_rd_reg  in  XLEN  ALU result for non-load instructions
o_exec_stall  out  1  exec must hold all inputs stable
o_ram_rd_en  out  1  RAM read strobe
o_ram_wr_en  out  1  RAM write strobe
o_ram_addr  out  XLEN  dword-aligned address (bits [2:0] = 0)
o_ram_mask  out  MASK_WIDTH  byte enables
o_ram_wr_data  out  XLEN  store data, lane-positioned
i_ram_rd_data  in  XLEN  read data, valid in the same cycle as the address (asynchronous read)
o_wb_valid  out  1  registered result valid
o_wb_rd_en  out  1  registered rd write enable
o_wb_rd  out  5  registered rd
o_wb_rd_reg  out  XLEN  registered result

Behaviour:
- Reset, async, i_rst_n low: FSM goes to ACCESS; all o_wb_* outputs are 0; the hold register is cleared; o_exec_stall is 0. The o_ram_* outputs are combinational and are 0 while the FSM is in ACCESS with i_exec_valid low.
- Byte offset: off = addr[2:0]. Byte count: nb = 1<<size. Wide mask: m16 = ((1<<nb)-1) << off (16 bits). Wide store data: d128 = wdata << (8*off). split = |m16[15:8].
- ACCESS state, aligned case (valid and not split): a single combinational beat. o_ram_addr = {addr[63:3],3'b0}, mask = m16[7:0], wr_data = d128[63:0]. The result is registered at the next edge, so latency is 1 cycle and o_exec_stall stays 0.
- ACCESS state, split case: drives beat 0 (low dword, m16[7:0], d128[63:0]). If a load, i_ram_rd_data is captured into the hold register. o_exec_stall = 1 (combinational). Next state is SECOND. No wb update this edge; o_wb_valid <= 0.
- SECOND state: drives beat 1. Address is the low dword address + 8, wrapping modulo 2^64. mask = m16[15:8], wr_data = d128[127:64]. o_exec_stall = 0. Load data is {i_ram_rd_data, hold} >> (8*off). Result is registered and the FSM returns to ACCESS. Total latency for a split access is 2 cycles.
- Load extract: take the low 8*nb bits, then sign- or zero-extend per i_exec_sign. size=3 ignores sign.
- Stores: o_wb_rd_en <= 0 and o_wb_valid <= 1.
- Non-memory instructions (valid, no ld, no st): no RAM strobes. o_wb_rd_reg <= i_exec_rd_reg; rd_en and rd pass through.
- ld and st both high: treated as a store; rd_en is forced to 0.
- i_exec_valid low in ACCESS: no strobes and o_wb_valid <= 0. o_wb_rd_reg holds its value.
- Reset during SECOND: beat 1 is abandoned and the FSM returns to ACCESS. A split store may leave the low half written; this is accepted.
- o_ram_rd_en and o_ram_wr_en are never both high.

Decomposition:
- Shared package nnrv_pkg: size encodings (SZ_B/H/W/D), FSM state encoding (ST_ACCESS, ST_SECOND).
- Sub-module nnrv_load_extract: combinational shift, width select and sign-extend (data, off, size, sign -> XLEN).
- Mask and store-shift logic stays inline.

Test Plan:
- lw, addr=0x1004, sign=1, RAM dword=0x8765432111223344 -> beat 0 at 0x1000, mask 0xF0, no stall; next cycle o_wb_rd_reg=0xFFFFFFFF87654321.
- lbu, addr=0x2007, RAM=0xAB00...00 -> mask 0x80; o_wb_rd_reg=0x00000000000000AB. Same with lb -> 0xFFFFFFFFFFFFFFAB.
- sd, addr=0x3005, wdata=0x0102030405060708 -> beat 0 at 0x3000, mask 0xE0, data 0x060708xx_xxxxxxxx; stall=1. Beat 1 at 0x3008, mask 0x1F, data 0x0000000102030405; stall released after beat 1.
- ld split, addr=0x4006; low RAM=0x2211xxxxxxxxxxxx, high=0x0000887766554433 -> o_wb_rd_reg=0x8877665544332211 after 2 cycles.
- Non-memory op, rd=5, rd_reg=0x42 -> no RAM strobes; next cycle o_wb_rd_en=1, o_wb_rd=5, o_wb_rd_reg=0x42.
- Assert i_rst_n low during SECOND of a split load -> FSM returns to ACCESS, o_wb_valid=0, o_exec_stall=0; the next aligned access completes normally.
